ofdm_frame_sequencer: RTL and testbench

- Transmit-side frame controller for the OFDM modem.
- Sequences one frame as: preamble ROM readout, then N payload OFDM symbols pulled from the IFFT/CP stage, then a zero-sample guard gap.
- Drives the preamble ROM address and the output mux select, and produces a valid strobe aligned with synchronous-ROM/payload data for the DAC-side stream.

---
 rtl/ofdm_tx_pkg.sv | 30 +++
 rtl/ofdm_frame_sequencer_counter.sv | 37 +++
 rtl/ofdm_frame_sequencer.sv | 149 ++++++++++++++
 tb/tb_ofdm_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the OFDM transmit frame path.
//   state_t       : frame sequencer states (IDLE/PRE/PAY/GAP)
//   SEL_*         : output mux select codes (zero / preamble / payload)
//   DEF_*         : default preamble and symbol lengths
//   sel_for_state : mux code that a beat in a given state produces
package ofdm_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_PAY  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_PRE  = 2'd1;
  localparam logic [1:0] SEL_PAY  = 2'd2;

  localparam int unsigned DEF_PRE_LEN = 107;
  localparam int unsigned DEF_SYM_LEN = 80;

  function automatic logic [1:0] sel_for_state(input state_t s);
    case (s)
      ST_PRE:  return SEL_PRE;
      ST_PAY:  return SEL_PAY;
      default: return SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/ofdm_frame_sequencer_counter.sv
// seq_beat_counter: modulo-MODULUS counter used for the frame sequencer's
// preamble address, payload sample count and gap count.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous clear to 0 (priority over en)
//   en         : advance by one; wraps to 0 after MODULUS-1
//   count      : current count
//   tc         : count is at its terminal value MODULUS-1
module seq_beat_counter
  import ofdm_tx_pkg::*;
#(
  parameter int unsigned WIDTH   = 7,
  parameter int unsigned MODULUS = DEF_PRE_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + STEP;
    end
  end

endmodule

// File: rtl/ofdm_frame_sequencer.sv
// ofdm_frame_sequencer: transmit frame controller. One frame is the preamble
// ROM readout, n_symbols payload OFDM symbols, then a zero-sample gap.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : frame request, accepted only when idle
//   n_symbols   : payload symbol count, captured on accepted start
//   abort       : synchronous return to idle (beats the start and any beat)
//   ready_in    : downstream accepts a sample this cycle
//   pl_valid    : payload source has a sample
//   pl_ready    : payload sample consumed (ready_in while in PAY)
//   rom_addr    : registered preamble ROM address
//   out_sel     : mux select for the sample emitted with out_valid
//   out_valid   : sample valid, one cycle after its beat
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last gap beat
module ofdm_frame_sequencer
  import ofdm_tx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned PRE_LEN    = DEF_PRE_LEN,
  parameter int unsigned SYM_LEN    = DEF_SYM_LEN,
  parameter int unsigned NSYM_WIDTH = 8,
  parameter int unsigned GAP_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NSYM_WIDTH-1:0] n_symbols,
  input  logic                  abort,
  input  logic                  ready_in,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [1:0]            out_sel,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned SAMP_W = $clog2(SYM_LEN);
  localparam int unsigned GAP_W  = $clog2(GAP_LEN + 1);

  localparam logic [SAMP_W-1:0]     SAMP_LAST = SAMP_W'(SYM_LEN - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP_LEN - 1);
  localparam logic [NSYM_WIDTH-1:0] SYM_ONE   = NSYM_WIDTH'(1);

  state_t state, state_next;

  logic [NSYM_WIDTH-1:0] nsym_q;
  logic [NSYM_WIDTH-1:0] sym_cnt;
  logic [SAMP_W-1:0]     samp_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  addr_tc, samp_tc, gap_tc;

  logic accept, beat, pre_beat, pay_beat, gap_beat, cnt_clear;
  logic sym_last, pay_last, gap_last;

  always_comb begin
    accept = (state == ST_IDLE) && start && !abort;
    beat   = 1'b0;
    case (state)
      ST_PRE:  beat = ready_in;
      ST_PAY:  beat = pl_valid && ready_in;
      ST_GAP:  beat = ready_in;
      default: beat = 1'b0;
    endcase
    beat      = beat && !abort;
    pre_beat  = beat && (state == ST_PRE);
    pay_beat  = beat && (state == ST_PAY);
    gap_beat  = beat && (state == ST_GAP);
    cnt_clear = abort || accept;
    sym_last  = (sym_cnt == nsym_q - SYM_ONE);
    pay_last  = pay_beat && (samp_cnt == SAMP_LAST) && sym_last;
    gap_last  = gap_beat && (gap_cnt == GAP_LAST);
  end

  seq_beat_counter #(.WIDTH(ADDR_WIDTH), .MODULUS(PRE_LEN)) u_addr_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (pre_beat),
    .count (rom_addr),
    .tc    (addr_tc)
  );

  seq_beat_counter #(.WIDTH(SAMP_W), .MODULUS(SYM_LEN)) u_samp_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (pay_beat),
    .count (samp_cnt),
    .tc    (samp_tc)
  );

  seq_beat_counter #(.WIDTH(GAP_W), .MODULUS(GAP_LEN)) u_gap_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (gap_beat),
    .count (gap_cnt),
    .tc    (gap_tc)
  );

  always_comb begin
    state_next = state;
    pl_ready   = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (accept) state_next = ST_PRE;
      ST_PRE:  if (pre_beat && addr_tc) state_next = (nsym_q != '0) ? ST_PAY : ST_GAP;
      ST_PAY: begin
        pl_ready = ready_in;
        if (pay_last) state_next = ST_GAP;
      end
      ST_GAP:  if (gap_last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      nsym_q     <= '0;
      sym_cnt    <= '0;
      out_valid  <= 1'b0;
      out_sel    <= SEL_ZERO;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      out_valid  <= beat;
      frame_done <= gap_beat && gap_tc;
      if (accept) nsym_q <= n_symbols;
      if (cnt_clear) begin
        sym_cnt <= '0;
      end else if (pay_beat && samp_tc) begin
        sym_cnt <= sym_last ? '0 : sym_cnt + SYM_ONE;
      end
      // Select follows the last beat's source; forced to zero once idle.
      if (abort) begin
        out_sel <= SEL_ZERO;
      end else if (beat) begin
        out_sel <= sel_for_state(state);
      end else if (state == ST_IDLE) begin
        out_sel <= SEL_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
module tb_ofdm_frame_sequencer;

  localparam int unsigned PRE = 107;
  localparam int unsigned SYM = 80;
  localparam int unsigned GAP = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] n_symbols;
  logic       abort;
  logic       ready_in;
  logic       pl_valid;
  logic       pl_ready;
  logic [6:0] rom_addr;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       busy;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ofdm_frame_sequencer #(
    .ADDR_WIDTH (7),
    .PRE_LEN    (PRE),
    .SYM_LEN    (SYM),
    .NSYM_WIDTH (8),
    .GAP_LEN    (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .n_symbols  (n_symbols),
    .abort      (abort),
    .ready_in   (ready_in),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .rom_addr   (rom_addr),
    .out_sel    (out_sel),
    .out_valid  (out_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a single run of beats indexed by k; the segment
  // (preamble / payload / gap) follows from k alone.
  logic        m_active, m_valid, m_done, m_beat;
  logic [1:0]  m_sel;
  int unsigned m_k, m_n, m_seg, m_total;

  function automatic int unsigned seg_of(input int unsigned k, input int unsigned n);
    if (k < PRE) return 1;
    if (k < PRE + n * SYM) return 2;
    return 3;
  endfunction

  function automatic logic [1:0] sel_of_seg(input int unsigned s);
    return (s == 1) ? 2'd1 : (s == 2) ? 2'd2 : 2'd0;
  endfunction

  always_comb begin
    m_seg   = seg_of(m_k, m_n);
    m_total = PRE + m_n * SYM + GAP;
    m_beat  = 1'b0;
    if (m_active && !abort)
      m_beat = (m_seg == 2) ? (pl_valid && ready_in) : ready_in;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_n      <= 0;
      m_valid  <= 1'b0;
      m_sel    <= 2'd0;
      m_done   <= 1'b0;
    end else begin
      m_valid <= m_beat;
      m_done  <= m_beat && (m_k == m_total - 1);
      if (abort) begin
        m_active <= 1'b0;
        m_k      <= 0;
        m_sel    <= 2'd0;
      end else if (!m_active) begin
        m_sel <= 2'd0;
        if (start) begin
          m_active <= 1'b1;
          m_k      <= 0;
          m_n      <= n_symbols;
        end
      end else if (m_beat) begin
        m_sel <= sel_of_seg(m_seg);
        if (m_k == m_total - 1) begin
          m_active <= 1'b0;
          m_k      <= 0;
        end else begin
          m_k <= m_k + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rom_addr",   rom_addr,   (m_active && m_k < PRE) ? m_k : 0);
    chk("out_valid",  out_valid,  m_valid);
    chk("out_sel",    out_sel,    m_sel);
    chk("busy",       busy,       m_active);
    chk("pl_ready",   pl_ready,   m_active && (m_seg == 2) && ready_in);
    chk("frame_done", frame_done, m_done);
  end

  // Per-test observation statistics, sampled 2 time units after each edge.
  int nv, nd, run_len, max_run, sel_code;
  logic [1:0] last_sel;
  logic       have_sel;

  task automatic clear_stats();
    nv = 0; nd = 0; run_len = 0; max_run = 0; sel_code = 0; have_sel = 1'b0; last_sel = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (out_valid) begin
      nv++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (!have_sel || out_sel != last_sel) begin
        sel_code = sel_code * 10 + int'(out_sel);
        last_sel = out_sel;
        have_sel = 1'b1;
      end
    end else begin
      run_len = 0;
    end
    if (frame_done) nd++;
  endtask

  task automatic start_frame(input int unsigned n);
    n_symbols = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && nd == 0; i++) tick();
    chk("frame_done_seen", nd, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; n_symbols = '0; abort = 1'b0;
    ready_in = 1'b0; pl_valid = 1'b0;
    clear_stats();
    tick(); tick();
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    tick();

    // Full frame, two symbols, no backpressure.
    ready_in = 1'b1; pl_valid = 1'b1;
    clear_stats();
    start_frame(2);
    run_until_done(400);
    chk("full_valid_cnt", nv, 283);
    chk("full_valid_run", max_run, 283);
    chk("full_sel_seq", sel_code, 120);
    for (int i = 0; i < 3; i++) tick();
    chk("full_done_once", nd, 1);
    chk("full_busy_low", busy, 0);

    // Backpressure in the preamble: ready_in alternates 1,0.
    clear_stats();
    start_frame(1);
    for (int i = 0; i < 20; i++) begin
      ready_in = (i % 2 == 0);
      tick();
    end
    chk("bp_addr", rom_addr, 10);
    chk("bp_valid_cnt", nv, 10);
    ready_in = 1'b1;
    run_until_done(400);
    chk("bp_total_valid", nv, 203);

    // Payload starvation after 40 samples of the first symbol.
    clear_stats();
    start_frame(1);
    for (int i = 0; i < PRE + 40; i++) tick();
    pl_valid = 1'b0;
    begin
      int lows = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("starve_pl_ready", pl_ready, 1);
        if (!out_valid) lows++;
      end
      chk("starve_valid_low", lows, 5);
    end
    pl_valid = 1'b1;
    run_until_done(400);
    chk("starve_total_valid", nv, 203);

    // Zero payload symbols: preamble straight into the gap.
    clear_stats();
    start_frame(0);
    run_until_done(300);
    chk("zero_valid_cnt", nv, 123);
    chk("zero_sel_seq", sel_code, 10);

    // Abort at rom_addr 50, then simultaneous start+abort while idle.
    clear_stats();
    start_frame(1);
    for (int i = 0; i < 50; i++) tick();
    chk("abort_pre_addr", rom_addr, 50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_addr", rom_addr, 0);
    chk("abort_valid", out_valid, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_done", nd, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    tick();

    // start and n_symbols changes while busy are ignored.
    clear_stats();
    start_frame(1);
    for (int i = 0; i < 30; i++) tick();
    n_symbols = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(400);
    chk("busy_start_valid", nv, 203);

    // Asynchronous reset mid-frame, then replay from address 0.
    clear_stats();
    start_frame(1);
    for (int i = 0; i < 20; i++) tick();
    #1 reset = 1'b1;
    #1;
    chk("midrst_addr", rom_addr, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sel", out_sel, 0);
    tick();
    reset = 1'b0;
    tick();
    clear_stats();
    start_frame(1);
    for (int i = 0; i < 3; i++) tick();
    chk("replay_addr", rom_addr, 3);
    run_until_done(400);
    chk("replay_total_valid", nv, 203);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
